seq_pattern_encoder: RTL and testbench
======================================

Name: seq_pattern_encoder

Overview:
- Memory-to-memory bit-stream encoder and pattern detector.
- Word 0 of the read memory holds stream length N. Words 1..N carry one stream bit each, in RData[0].
- For every stream bit it writes one tag word: bit value, a pattern-hit flag, and a saturating running match count.
- Programmable pattern, pattern length and overlap mode. Start/Finish handshake lets a controller run back-to-back jobs.

Parameters:
AW, 15, read/write address width; also width of the length field in word 0
DW, 15, read data width
OW, 5, write data width (min 3)
PMAX, 8, maximum pattern length in bits
PLW, 4, width of pat_len (must hold PMAX)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets)
start  input  1  single-cycle job request, honoured only in IDLE
pattern  input  PMAX  pattern; pattern[0] = most recent bit
pat_len  input  PLW  pattern length; 0 treated as 1, >PMAX clamped to PMAX
overlap  input  1  1 = overlapping matches counted; 0 = history cleared after a hit
RData  input  DW  read data, combinational w.r.t. RAddr (same-cycle)
RAddr  output  AW  read address
WAddr  output  AW  write address
WData  output  OW  tag word
Wen  output  1  write enable
Finish  output  1  job complete, level, held until next accepted start
busy  output  1  job in progress

Behaviour:
- Reset (rst=0, async): state IDLE; RAddr=0, WAddr=0, WData=0, Wen=0, Finish=0, busy=0; history, counters and config registers cleared.
- pattern, pat_len and overlap are latched on the start-accept cycle; input changes mid-job are ignored.
- start while busy: ignored.
- States: IDLE -> LEN -> RUN -> FLUSH -> DONE -> (start) LEN.
- IDLE: on start, go to LEN with busy=1 and Finish=0.
- LEN: RAddr=0; latch N=RData[AW-1:0]. If N=0, go to DONE. Else go to RUN with bit index k=0.
- RUN, cycle k: RAddr=k+1; sample b=RData[0].
  - history h <= {h[PMAX-2:0], b}; valid-bit counter v <= min(v+1, PMAX).
  - hit = (v+1 >= L) and (h_next[L-1:0] == pattern[L-1:0]), where L = effective pat_len.
  - On the last bit (k=N-1), go to FLUSH.
- Write pipeline: results of RUN cycle k are registered. On the next cycle Wen=1, WAddr=k, WData = {b, hit, cnt}.
  - cnt is the running hit count including this hit, width OW-2, saturating at 2^(OW-2)-1.
  - Write latency is 1 cycle after the read.
- Hit in non-overlap mode: v <= 0 after the hit, so the next hit needs L fresh bits. h is not cleared.
- FLUSH: performs the final write, then goes to DONE.
- DONE: Finish=1, busy=0, Wen=0. Go to LEN on start; otherwise hold.
- Wen=0 in every cycle other than the registered write cycle.
- Max N = 2^AW-1; RAddr must not wrap. No other address arithmetic wraps.
- The hit counter and history reset on every accepted start.
- rst asserted mid-job: immediate abort to reset values; no further writes.

Decomposition:
- Shared package: state encoding enum (IDLE, LEN, RUN, FLUSH, DONE) and the tag field positions (BIT_POS=OW-1, HIT_POS=OW-2, CNT_W=OW-2).
- One sub-module: seq_pattern_match. It holds the history shift register, valid counter, effective-length clamp and compare, and outputs hit combinationally from the incoming bit.

Test Plan:
- pattern=0b1101, pat_len=4, overlap=1, N=7, bits 1,1,0,1,1,0,1 -> writes to addr 0..6; addr3=5'b11001, addr6=5'b11010; all others have hit=0; Finish rises 1 cycle after the addr6 write.
- Same stream, overlap=0 -> addr3=5'b11001, addr6=5'b10001 (no hit, count stays 1).
- pattern=0b1, pat_len=1, N=10, all ones -> counts 1..7 then saturate; addr6..addr9 = 5'b11111.
- N=0 -> no Wen pulse; Finish=1 two cycles after start; busy high only in the LEN cycle.
- start pulsed while busy, and pattern changed mid-job -> ignored; output identical to the first test; second start after Finish runs a fresh job with count restarting at 1.
- rst=0 asserted during RUN at k=3 -> all outputs reach reset values asynchronously; after release, a new start completes normally.

Source files
------------

// File: rtl/seq_pattern_encoder_pkg.sv
// Shared types and tag-word layout helpers for the sequence pattern encoder.
package seq_pattern_encoder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StRun,
        StFlush,
        StDone
    } state_e;

    // Tag word layout: {bit, hit, count}, MSB first.
    function automatic int unsigned tag_bit_pos(input int unsigned ow);
        return ow - 1;
    endfunction

    function automatic int unsigned tag_hit_pos(input int unsigned ow);
        return ow - 2;
    endfunction

    function automatic int unsigned tag_cnt_w(input int unsigned ow);
        return ow - 2;
    endfunction

endpackage

// File: rtl/seq_pattern_encoder_if.sv
// Job-control, pattern-config and memory-port bundle for the sequence pattern encoder.
interface seq_pattern_encoder_if #(
    parameter int unsigned AW   = 15,
    parameter int unsigned DW   = 15,
    parameter int unsigned OW   = 5,
    parameter int unsigned PMAX = 8,
    parameter int unsigned PLW  = 4
) ();

    logic            start;
    logic [PMAX-1:0] pattern;
    logic [PLW-1:0]  pat_len;
    logic            overlap;
    logic [DW-1:0]   RData;
    logic [AW-1:0]   RAddr;
    logic [AW-1:0]   WAddr;
    logic [OW-1:0]   WData;
    logic            Wen;
    logic            Finish;
    logic            busy;

    modport master (
        output start, pattern, pat_len, overlap, RData,
        input  RAddr, WAddr, WData, Wen, Finish, busy
    );

    modport slave (
        input  start, pattern, pat_len, overlap, RData,
        output RAddr, WAddr, WData, Wen, Finish, busy
    );

endinterface

// File: rtl/seq_pattern_match.sv
// Bit-history shift register with valid-bit tracking; flags a pattern hit
// combinationally from the incoming bit.
module seq_pattern_match #(
    parameter int unsigned PMAX = 8,
    parameter int unsigned PLW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_en,
    input  logic            i_bit,
    input  logic [PMAX-1:0] i_pattern,
    input  logic [PLW-1:0]  i_pat_len,
    input  logic            i_overlap,
    output logic            o_hit
);

    localparam int unsigned VW = $clog2(PMAX + 1);

    logic [PMAX-1:0] r_hist;
    logic [VW-1:0]   r_valid;
    logic [PMAX-1:0] w_hist_nxt;
    logic [PMAX-1:0] w_mask;
    int              w_len;
    logic            w_hit;

    always_comb begin
        w_mask = '0;
        if (i_pat_len == '0) begin
            w_len = 1;
        end else if (int'(i_pat_len) > int'(PMAX)) begin
            w_len = int'(PMAX);
        end else begin
            w_len = int'(i_pat_len);
        end
        for (int i = 0; i < int'(PMAX); i++) begin
            w_mask[i] = (i < w_len);
        end
    end

    assign w_hist_nxt = {r_hist[PMAX-2:0], i_bit};
    // A hit needs at least L valid bits, counting the one arriving now.
    assign w_hit = i_en && ((int'(r_valid) + 1) >= w_len) &&
                   (((w_hist_nxt ^ i_pattern) & w_mask) == '0);
    assign o_hit = w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist  <= '0;
            r_valid <= '0;
        end else if (i_clear) begin
            r_hist  <= '0;
            r_valid <= '0;
        end else if (i_en) begin
            r_hist <= w_hist_nxt;
            if (w_hit && !i_overlap) begin
                r_valid <= '0;
            end else if (int'(r_valid) < int'(PMAX)) begin
                r_valid <= r_valid + VW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_pattern_encoder.sv
// Memory-to-memory bit-stream encoder: reads N stream bits, writes one
// {bit, hit, count} tag word per bit one cycle after each read.
module seq_pattern_encoder
    import seq_pattern_encoder_pkg::*;
#(
    parameter int unsigned AW   = 15,
    parameter int unsigned DW   = 15,
    parameter int unsigned OW   = 5,
    parameter int unsigned PMAX = 8,
    parameter int unsigned PLW  = 4
) (
    input logic                  clk,
    input logic                  rst,
    seq_pattern_encoder_if.slave bus
);

    localparam int unsigned BIT_POS = tag_bit_pos(OW);
    localparam int unsigned HIT_POS = tag_hit_pos(OW);
    localparam int unsigned CNT_W   = tag_cnt_w(OW);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [AW-1:0]   r_len;
    logic [AW-1:0]   r_ridx;
    logic [AW-1:0]   r_waddr;
    logic [OW-1:0]   r_wdata;
    logic            r_wen;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PMAX-1:0] r_pattern;
    logic [PLW-1:0]  r_pat_len;
    logic            r_overlap;
    logic            w_accept;
    logic            w_run;
    logic            w_last;
    logic            w_bit;
    logic            w_hit;
    logic [OW-1:0]   w_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (bus.start) begin
                    w_state_nxt = StLen;
                    w_accept    = 1'b1;
                end
            end
            StLen:   w_state_nxt = (bus.RData[AW-1:0] == '0) ? StDone : StRun;
            StRun:   w_state_nxt = w_last ? StFlush : StRun;
            StFlush: w_state_nxt = StDone;
            default: w_state_nxt = StIdle;
        endcase
    end

    // r_ridx holds k+1 during RUN, i.e. the read address of the current bit.
    assign w_run  = (r_state == StRun);
    assign w_last = (r_ridx == r_len);
    assign w_bit  = bus.RData[0];

    assign w_cnt_nxt = (w_hit && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

    always_comb begin
        w_tag                = '0;
        w_tag[BIT_POS]       = w_bit;
        w_tag[HIT_POS]       = w_hit;
        w_tag[CNT_W-1:0]     = w_cnt_nxt;
    end

    seq_pattern_match #(
        .PMAX (PMAX),
        .PLW  (PLW)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_en      (w_run),
        .i_bit     (w_bit),
        .i_pattern (r_pattern),
        .i_pat_len (r_pat_len),
        .i_overlap (r_overlap),
        .o_hit     (w_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len     <= '0;
            r_ridx    <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wen     <= 1'b0;
            r_cnt     <= '0;
            r_pattern <= '0;
            r_pat_len <= '0;
            r_overlap <= 1'b0;
        end else begin
            r_wen <= w_run;
            if (w_accept) begin
                r_pattern <= bus.pattern;
                r_pat_len <= bus.pat_len;
                r_overlap <= bus.overlap;
                r_cnt     <= '0;
            end
            if (r_state == StLen) begin
                r_len  <= bus.RData[AW-1:0];
                r_ridx <= AW'(1);
            end
            if (w_run) begin
                r_cnt   <= w_cnt_nxt;
                r_waddr <= r_ridx - AW'(1);
                r_wdata <= w_tag;
                if (!w_last) begin
                    r_ridx <= r_ridx + AW'(1);
                end
            end
        end
    end

    assign bus.RAddr  = w_run ? r_ridx : '0;
    assign bus.WAddr  = r_waddr;
    assign bus.WData  = r_wdata;
    assign bus.Wen    = r_wen;
    assign bus.Finish = (r_state == StDone);
    assign bus.busy   = (r_state == StLen) || (r_state == StRun) || (r_state == StFlush);

endmodule

// File: tb/tb_seq_pattern_encoder.sv
// Self-checking bench: directed vector table, handshake/reset corner cases and
// randomized jobs checked against a stream-level reference model.
module tb_seq_pattern_encoder;

    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 15;
    localparam int unsigned OW   = 5;
    localparam int unsigned PMAX = 8;
    localparam int unsigned PLW  = 4;
    localparam int          MAXN = 60;

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  plen;
        logic        ovl;
        int          n;
        logic [63:0] bits;
        int          addr_a;
        logic [4:0]  exp_a;
        int          addr_b;
        logic [4:0]  exp_b;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [OW-1:0] data;
        int            cyc;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          sbits [0:MAXN-1];
    logic [OW-1:0] exp_w [0:MAXN-1];
    logic [OW-1:0] got_w [0:MAXN-1];
    wr_t           wr_q [$];
    vec_t          vecs [6];

    seq_pattern_encoder_if #(
        .AW(AW), .DW(DW), .OW(OW), .PMAX(PMAX), .PLW(PLW)
    ) bus ();

    seq_pattern_encoder #(
        .AW(AW), .DW(DW), .OW(OW), .PMAX(PMAX), .PLW(PLW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.RData = mem[bus.RAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Wen) wr_q.push_back('{bus.WAddr, bus.WData, cyc});
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", name, got, exp);
    endtask

    // Reference: a hit is the last L stream bits matching pattern (newest in
    // pattern[0]), with at least L bits seen since start or, without overlap,
    // since the previous hit.
    function automatic void model(input vec_t v);
        int len;
        int fresh;
        int hits;
        logic hit;
        len = (v.plen == 0) ? 1 : ((int'(v.plen) > int'(PMAX)) ? int'(PMAX) : int'(v.plen));
        fresh = 0;
        hits  = 0;
        for (int k = 0; k < v.n; k++) begin
            fresh++;
            hit = (fresh >= len);
            for (int j = 0; j < len; j++) begin
                if (k - j < 0) hit = 1'b0;
                else if (sbits[k-j] != v.pat[j]) hit = 1'b0;
            end
            if (hit) begin
                hits++;
                if (!v.ovl) fresh = 0;
            end
            exp_w[k] = {sbits[k], hit, 3'((hits > 7) ? 7 : hits)};
        end
    endfunction

    task automatic run_job(input vec_t v, input bit disturb);
        int t;
        int acc_cyc;
        int fin_cyc;
        int last_cyc;
        for (int k = 0; k < MAXN; k++) begin
            sbits[k] = v.bits[k];
            got_w[k] = '0;
        end
        model(v);
        mem[0] = DW'(v.n);
        for (int k = 0; k < v.n; k++) mem[k+1] = DW'(sbits[k]);
        wr_q.delete();
        @(negedge clk);
        bus.pattern = v.pat;
        bus.pat_len = v.plen;
        bus.overlap = v.ovl;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        acc_cyc   = cyc;
        chk("busy_in_len", bus.busy, 1);
        chk("finish_cleared", bus.Finish, 0);
        t = 0;
        while (!bus.Finish && t < 200) begin
            if (disturb && t == 2) begin
                bus.start   = 1'b1;
                bus.pattern = ~v.pat;
                bus.pat_len = v.plen + 4'd1;
                bus.overlap = ~v.ovl;
            end else if (disturb && t == 3) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        fin_cyc = cyc;
        chk("finish_seen", bus.Finish, 1);
        chk("busy_done", bus.busy, 0);
        chk("n_writes", wr_q.size(), v.n);
        last_cyc = acc_cyc;
        foreach (wr_q[i]) begin
            if (i < MAXN) begin
                chk($sformatf("waddr[%0d]", i), wr_q[i].addr, i);
                chk($sformatf("wdata[%0d]", i), wr_q[i].data, exp_w[i]);
                if (int'(wr_q[i].addr) < MAXN) got_w[wr_q[i].addr] = wr_q[i].data;
            end
            last_cyc = wr_q[i].cyc;
        end
        if (v.n > 0) chk("finish_after_last_wr", fin_cyc - last_cyc, 1);
        else chk("finish_after_len", fin_cyc - acc_cyc, 1);
        if (v.addr_a >= 0) chk($sformatf("tag_a@%0d", v.addr_a), got_w[v.addr_a], v.exp_a);
        if (v.addr_b >= 0) chk($sformatf("tag_b@%0d", v.addr_b), got_w[v.addr_b], v.exp_b);
    endtask

    initial begin
        vec_t rv;
        int   t;
        int   wr_sz;
        n_chk  = 0;
        n_pass = 0;
        vecs[0] = '{8'h0D, 4'd4, 1'b1, 7, 64'h5B, 3, 5'b11001, 6, 5'b11010};
        vecs[1] = '{8'h0D, 4'd4, 1'b0, 7, 64'h5B, 3, 5'b11001, 6, 5'b10001};
        vecs[2] = '{8'h01, 4'd1, 1'b1, 10, 64'h3FF, 6, 5'b11111, 9, 5'b11111};
        vecs[3] = '{8'h0D, 4'd4, 1'b1, 0, 64'h0, -1, 5'b0, -1, 5'b0};
        vecs[4] = '{8'h00, 4'd0, 1'b1, 3, 64'h2, 0, 5'b01001, 2, 5'b01010};
        vecs[5] = '{8'hA5, 4'd12, 1'b1, 8, 64'hA5, 7, 5'b11001, 6, 5'b00000};

        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.pat_len = '0;
        bus.overlap = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_raddr", bus.RAddr, 0);
        chk("rst_waddr", bus.WAddr, 0);
        chk("rst_wdata", bus.WData, 0);
        chk("rst_wen", bus.Wen, 0);
        chk("rst_finish", bus.Finish, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_job(vecs[i], 1'b0);

        // Mid-job start and config changes must not disturb the running job.
        run_job(vecs[0], 1'b1);
        run_job(vecs[0], 1'b0);

        // Asynchronous reset during RUN at k=3.
        for (int k = 0; k < 7; k++) sbits[k] = vecs[0].bits[k];
        mem[0] = DW'(7);
        for (int k = 0; k < 7; k++) mem[k+1] = DW'(sbits[k]);
        @(negedge clk);
        bus.pattern = vecs[0].pat;
        bus.pat_len = vecs[0].plen;
        bus.overlap = vecs[0].ovl;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (bus.RAddr != AW'(4) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reach_k3", bus.RAddr, 4);
        #1 rst = 1'b0;
        #1;
        chk("arst_raddr", bus.RAddr, 0);
        chk("arst_waddr", bus.WAddr, 0);
        chk("arst_wdata", bus.WData, 0);
        chk("arst_wen", bus.Wen, 0);
        chk("arst_finish", bus.Finish, 0);
        chk("arst_busy", bus.busy, 0);
        wr_sz = wr_q.size();
        repeat (3) @(negedge clk);
        chk("no_wr_in_reset", wr_q.size(), wr_sz);
        rst = 1'b1;
        run_job(vecs[0], 1'b0);

        for (int r = 0; r < 25; r++) begin
            rv.pat    = 8'($urandom);
            rv.plen   = (r % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            rv.ovl    = 1'($urandom);
            rv.n      = $urandom_range(0, 40);
            rv.bits   = {$urandom, $urandom};
            rv.addr_a = -1;
            rv.exp_a  = '0;
            rv.addr_b = -1;
            rv.exp_b  = '0;
            run_job(rv, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
